// File: rtl/tac_pulse_if.sv
// Sample handshake between an activation producer and the TAC pulse encoder.
// valid/ready: a sample transfers on a rising edge where in_valid and in_ready are both high; data is ignored otherwise.
interface tac_pulse_if #(
  parameter int MAG_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [MAG_W-1:0] in_mag;
  logic             in_sign;
  logic             in_last;

  modport master (
    output in_valid,
    output in_mag,
    output in_sign,
    output in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_mag,
    input  in_sign,
    input  in_last,
    output in_ready
  );
endinterface

// File: rtl/tac_pulse_encoder.sv
// Turns signed-magnitude samples into |x|-cycle tac_in pulse trains and frames
// them with a readout window (frame_valid/frame_ack) followed by a one-cycle tac_clr.
module tac_pulse_encoder #(
  parameter int MAG_W      = 8,
  parameter int GAP_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  tac_pulse_if.slave  in_if,
  output logic        tac_in,
  output logic        sign_x,
  output logic        busy,
  output logic        frame_valid,
  input  logic        frame_ack,
  output logic        tac_clr,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PULSE = 3'd1,
    GAP   = 3'd2,
    DONE  = 3'd3,
    CLEAR = 3'd4
  } state_t;

  localparam logic [MAG_W-1:0] CNT_ONE  = MAG_W'(1);
  localparam logic [MAG_W-1:0] CNT_ZERO = '0;
  localparam logic [3:0]       GAP_INIT = 4'(GAP_CYCLES);
  localparam logic [3:0]       GAP_ONE  = 4'd1;

  state_t           state_q, state_d;
  logic [MAG_W-1:0] cnt_q, cnt_d;
  logic [3:0]       gap_q, gap_d;
  logic             last_q, last_d;
  logic             sign_d;

  assign in_if.in_ready = (state_q == IDLE);
  assign busy           = (state_q != IDLE);
  assign state_dbg      = state_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    last_d  = last_q;
    sign_d  = sign_x;
    case (state_q)
      IDLE: begin
        if (in_if.in_valid) begin
          sign_d = in_if.in_sign;
          last_d = in_if.in_last;
          // A zero magnitude skips the train entirely but still spends the gap.
          if (in_if.in_mag != CNT_ZERO) begin
            cnt_d   = in_if.in_mag;
            state_d = PULSE;
          end else begin
            gap_d   = GAP_INIT;
            state_d = GAP;
          end
        end
      end
      PULSE: begin
        if (cnt_q == CNT_ONE) begin
          cnt_d   = CNT_ZERO;
          gap_d   = GAP_INIT;
          state_d = GAP;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      GAP: begin
        if (gap_q == GAP_ONE) begin
          gap_d   = 4'd0;
          state_d = last_q ? DONE : IDLE;
        end else begin
          gap_d = gap_q - GAP_ONE;
        end
      end
      DONE: begin
        if (frame_ack) begin
          last_d  = 1'b0;
          state_d = CLEAR;
        end
      end
      CLEAR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= CNT_ZERO;
      gap_q       <= 4'd0;
      last_q      <= 1'b0;
      sign_x      <= 1'b0;
      tac_in      <= 1'b0;
      frame_valid <= 1'b0;
      tac_clr     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gap_q       <= gap_d;
      last_q      <= last_d;
      sign_x      <= sign_d;
      tac_in      <= (state_d == PULSE);
      frame_valid <= (state_d == DONE);
      tac_clr     <= (state_d == CLEAR);
    end
  end

endmodule

// File: doc/tac_pulse_encoder.md
Name: tac_pulse_encoder

Overview:
- Upstream input stage for the signed temporal accumulator (TAC).
- Accepts signed-magnitude activation samples over a valid/ready handshake.
- Converts each sample to a tac_in pulse train lasting exactly |x| cycles, with sign_x held stable for the whole train.
- Frames a sequence of samples: at end of frame it offers a readout window to the consumer, then pulses a clear to the TAC.

Parameters:
- MAG_W, 8, width of sample magnitude; also the width of the pulse counter.
- GAP_CYCLES, 1, idle cycles (tac_in=0) inserted after every sample; legal range 1..15.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  sample offered.
- in_ready  output  1  encoder can accept a sample.
- in_mag  input  MAG_W  sample magnitude |x|, unsigned.
- in_sign  input  1  sample sign, forwarded unchanged to sign_x (1 = positive).
- in_last  input  1  sample is the final one of the frame.
- tac_in  output  1  pulse-train enable to the TAC.
- sign_x  output  1  registered sample sign to the TAC.
- busy  output  1  state != IDLE.
- frame_valid  output  1  TAC result is final and may be read.
- frame_ack  input  1  consumer has read the TAC result.
- tac_clr  output  1  one-cycle clear request to the TAC, ORed with rst outside this block.

Behaviour:
- All outputs are registered except in_ready and busy, which are decoded from state.
- Reset values: tac_in=0, sign_x=0, frame_valid=0, tac_clr=0, state=IDLE (so in_ready=1, busy=0). Pulse counter, gap counter and last flag are all 0.
- FSM states: IDLE, PULSE, GAP, DONE, CLEAR.
- IDLE:
  - in_ready=1.
  - On accept (in_valid&in_ready at edge k), latch mag, sign and last; sign_x updates at edge k.
  - If mag!=0, go to PULSE with cnt=mag. If mag==0, go directly to GAP; no tac_in pulse occurs.
- PULSE:
  - tac_in=1 during cycles k+1 .. k+mag inclusive, i.e. exactly mag cycles.
  - cnt decrements each cycle; on cnt==1, go to GAP.
  - Full scale mag=2^MAG_W-1 yields 255 cycles at the default width, with no counter wrap.
- GAP:
  - tac_in=0 for GAP_CYCLES cycles; sign_x is held.
  - Then go to DONE if last, else IDLE.
  - Next accept is possible at the earliest on edge k+mag+GAP_CYCLES+1.
- DONE:
  - frame_valid=1; it stays high until frame_ack is sampled high.
  - frame_ack is honoured in the first DONE cycle.
  - frame_ack outside DONE is ignored.
- CLEAR:
  - Entered on the edge after the acked DONE cycle: frame_valid=0, tac_clr=1 for exactly one cycle.
  - Then go to IDLE; tac_clr returns to 0.
- in_ready=0 in every state except IDLE. Samples never overlap, and in_mag, in_sign and in_last are ignored unless accepted.
- sign_x changes only on accept or reset, never mid-train.
- rst mid-operation:
  - Next cycle is in IDLE with all outputs at their reset values.
  - Any partial pulse train is truncated, and tac_clr is not asserted; the TAC is cleared by rst itself.
- A single-sample frame (in_last on the first sample) follows the same path: PULSE, then GAP, then DONE.

Test Plan:
- Accept mag=5, sign=1, last=0, GAP_CYCLES=1 -> tac_in high exactly 5 cycles starting 1 cycle after accept; sign_x=1 throughout; in_ready high again on 7th cycle after accept.
- Samples (3,+), (2,−), last on second -> tac_in bursts of 3 then 2, with sign_x 1 then 0 and a 1-cycle gap between; frame_valid rises after the second gap; frame_ack 4 cycles later -> tac_clr high for 1 cycle, then IDLE.
- mag=0 with last=1 -> no tac_in pulse; after GAP, frame_valid=1; ack -> tac_clr pulse.
- mag=255 -> tac_in high exactly 255 cycles; no wrap or early stop.
- Hold in_valid=1 continuously with changing data -> in_ready=0 during PULSE/GAP/DONE/CLEAR; only samples presented while in_ready=1 are encoded.
- Assert rst for 1 cycle in the middle of a mag=100 train -> tac_in=0, sign_x=0, frame_valid=0 next cycle; in_ready=1; no tac_clr pulse.
